fb_pattern_writer: RTL and testbench
====================================

FB_PATTERN_WRITER -- requirements
Module: fb_pattern_writer

Interface
REQ-001 SHALL provide parameter FB_WIDTH, default 128, framebuffer width in x positions.
REQ-002 SHALL provide parameter FB_HEIGHT, default 64, framebuffer height in y positions.
REQ-003 SHALL provide parameter TICK_CYCLES, default 27000000, clock cycles between WALK-mode writes (1 s at 27 MHz).
REQ-004 SHALL provide parameter ACK_TIMEOUT, default 1024, maximum cycles to wait for a write acknowledge.
REQ-005 SHALL provide parameter XW and YW, default 8 each, widths of the x and y position ports.
REQ-006 Ports, in order:
- clk, input, 1: single clock for the whole design.
- rst, input, 1: reset, synchronous and active-high.
- start, input, 1: begin a pattern run (level-sampled).
- stop, input, 1: abort the run.
- mode, input, 2: 0 WALK, 1 FILL, 2 CLEAR, 3 CHECKER.
- pattern_data, input, 8: byte written in WALK and FILL modes.
- fb_we, output, 1: framebuffer write enable.
- fb_w_xpos, output, XW: write x position.
- fb_w_ypos, output, YW: write y position.
- fb_din, output, 8: write data.
- fb_w_data_valid, input, 1: write acknowledge from the framebuffer.
- busy, output, 1: a run is in progress.
- done, output, 1: one-cycle pulse when a run ends normally.
- err, output, 1: sticky acknowledge-timeout flag.

Function
REQ-007 SHALL implement the states IDLE, WAIT_TICK, WRITE, ACK_LOW, ADVANCE and FINISH.
REQ-008 In IDLE with start=1, SHALL latch mode and pattern_data, clear the cursor to (0,0), and set busy=1 on the next cycle.
REQ-009 SHALL go from IDLE to WAIT_TICK in WALK mode and to WRITE in all other modes.
REQ-010 SHALL ignore start while busy=1, and SHALL ignore later changes on mode and pattern_data during a run.
REQ-011 In WAIT_TICK, SHALL count TICK_CYCLES cycles and then enter WRITE.
REQ-012 In WRITE, SHALL drive fb_we=1 with the cursor position and data, all held stable until fb_w_data_valid=1 is sampled.
REQ-013 On the cycle fb_w_data_valid=1 is sampled in WRITE, SHALL deassert fb_we on the next cycle and enter ACK_LOW.
REQ-014 In ACK_LOW, SHALL wait until fb_w_data_valid=0 is sampled and then enter ADVANCE, so that no new write starts while the acknowledge is high.
REQ-015 Data per mode SHALL be:
- WALK and FILL: the latched pattern_data.
- CLEAR: 8'h00.
- CHECKER: 8'hAA when (x[0]^y[0])=1, else 8'h55.
REQ-016 In ADVANCE, SHALL move the cursor as follows:
- x increments by 1.
- At x=FB_WIDTH-1, x wraps to 0 and y increments.
- At y=FB_HEIGHT-1 with x=FB_WIDTH-1, the frame is complete.
REQ-017 On frame complete, WALK mode SHALL wrap the cursor to (0,0) and continue from WAIT_TICK; the other modes SHALL enter FINISH.
REQ-018 Outside a completed frame, ADVANCE SHALL return to WAIT_TICK in WALK mode and to WRITE otherwise, so FILL, CLEAR and CHECKER writes run back-to-back.
REQ-019 FINISH SHALL pulse done=1 for exactly one cycle, clear busy, and return to IDLE.
REQ-020 In WAIT_TICK or ADVANCE, stop=1 SHALL return the block to IDLE on the next cycle with busy=0 and no done pulse.
REQ-021 stop=1 sampled in WRITE or ACK_LOW SHALL be recorded and acted on at the next ADVANCE, so an in-flight write always completes its handshake.
REQ-022 If the WRITE wait reaches ACK_TIMEOUT cycles, SHALL set err=1, deassert fb_we, and return to IDLE with busy=0 and no done pulse.
REQ-023 err SHALL stay set until rst, and a new start SHALL be accepted while err=1.
REQ-024 In every state other than WRITE, fb_we SHALL be 0.

Reset
REQ-025 rst=1 SHALL take priority over every other input, and a synchronous reset mid-run SHALL abort the run at once, including mid-handshake.
REQ-026 On reset, the following SHALL be cleared on the next clock edge:
- State returns to IDLE.
- Outputs fb_we, fb_w_xpos, fb_w_ypos, fb_din, busy, done and err all become 0.
- The cursor, tick counter and timeout counter all become 0.

Verification (bench parameters: FB_WIDTH=4, FB_HEIGHT=2, TICK_CYCLES=3, ACK_TIMEOUT=8; the acknowledge model answers 2 cycles after fb_we and holds for 1 cycle)
REQ-027 FILL with pattern_data=8'h3C -> exactly 8 writes, (0,0),(1,0)..(3,1), each with data 8'h3C, then one done pulse and busy=0.
REQ-028 CHECKER -> data sequence 55,AA,55,AA,AA,55,AA,55, with fb_we=0 in every cycle where the acknowledge is high.
REQ-029 WALK with pattern_data=8'hFF -> one write every 3 cycles plus handshake time; after 8 writes the cursor wraps to (0,0), with no done pulse and busy staying 1.
REQ-030 Acknowledge held low -> fb_we drops after 8 cycles, err=1, busy=0 and no done pulse; a later start is still accepted.
REQ-031 stop asserted during WRITE of (2,0) -> that write completes, no write to (3,0) occurs, and the block returns to IDLE.
REQ-032 rst asserted while fb_we=1 -> next cycle all outputs are 0 and state is IDLE; a start issued 2 cycles later writes (0,0) first.

Source files
------------

// File: rtl/fb_pattern_writer.sv
// rtl/fb_pattern_writer.sv - framebuffer test-pattern writer with ack handshake and timeout
//
// Ports:
//   clk              single clock
//   rst              synchronous active-high reset
//   start            begin a run (level-sampled in IDLE)
//   stop             abort the run (deferred while a write handshake is in flight)
//   mode             0 WALK, 1 FILL, 2 CLEAR, 3 CHECKER
//   pattern_data     byte written in WALK and FILL
//   fb_we            framebuffer write enable, high only in WRITE
//   fb_w_xpos        write x position
//   fb_w_ypos        write y position
//   fb_din           write data
//   fb_w_data_valid  write acknowledge from the framebuffer
//   busy             run in progress
//   done             one-cycle pulse on normal end of run
//   err              sticky acknowledge-timeout flag
module fb_pattern_writer #(
  parameter int FB_WIDTH    = 128,
  parameter int FB_HEIGHT   = 64,
  parameter int TICK_CYCLES = 27000000,
  parameter int ACK_TIMEOUT = 1024,
  parameter int XW          = 8,
  parameter int YW          = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [1:0]    mode,
  input  logic [7:0]    pattern_data,
  output logic          fb_we,
  output logic [XW-1:0] fb_w_xpos,
  output logic [YW-1:0] fb_w_ypos,
  output logic [7:0]    fb_din,
  input  logic          fb_w_data_valid,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [1:0] MODE_WALK    = 2'd0;
  localparam logic [1:0] MODE_CLEAR   = 2'd2;
  localparam logic [1:0] MODE_CHECKER = 2'd3;

  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [XW-1:0] X_LAST    = XW'(FB_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(FB_HEIGHT - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [AW-1:0] TO_LAST   = AW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    WRITE,
    ACK_LOW,
    ADVANCE,
    FINISH
  } state_t;

  state_t          state;
  logic [1:0]      mode_q;
  logic [7:0]      data_q;
  logic [XW-1:0]   cur_x;
  logic [YW-1:0]   cur_y;
  logic [TW-1:0]   tick_cnt;
  logic [AW-1:0]   to_cnt;
  logic            stop_pend;

  logic [XW-1:0]   nx;
  logic [YW-1:0]   ny;
  logic            frame_last;

  function automatic logic [7:0] pixel_data(input logic [1:0]    m,
                                            input logic [7:0]    d,
                                            input logic [XW-1:0] px,
                                            input logic [YW-1:0] py);
    logic [7:0] r;
    case (m)
      MODE_CLEAR:   r = 8'h00;
      MODE_CHECKER: r = (px[0] ^ py[0]) ? 8'hAA : 8'h55;
      default:      r = d;
    endcase
    return r;
  endfunction

  // Next cursor position in raster order; wraps to (0,0) after the last pixel.
  always_comb begin
    frame_last = 1'b0;
    nx         = cur_x + 1'b1;
    ny         = cur_y;
    if (cur_x == X_LAST) begin
      nx = '0;
      if (cur_y == Y_LAST) begin
        ny         = '0;
        frame_last = 1'b1;
      end else begin
        ny = cur_y + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= '0;
      data_q    <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      tick_cnt  <= '0;
      to_cnt    <= '0;
      stop_pend <= 1'b0;
      fb_we     <= 1'b0;
      fb_w_xpos <= '0;
      fb_w_ypos <= '0;
      fb_din    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          fb_we <= 1'b0;
          if (start) begin
            mode_q    <= mode;
            data_q    <= pattern_data;
            cur_x     <= '0;
            cur_y     <= '0;
            tick_cnt  <= '0;
            to_cnt    <= '0;
            stop_pend <= 1'b0;
            busy      <= 1'b1;
            if (mode == MODE_WALK) begin
              state <= WAIT_TICK;
            end else begin
              state     <= WRITE;
              fb_we     <= 1'b1;
              fb_w_xpos <= '0;
              fb_w_ypos <= '0;
              fb_din    <= pixel_data(mode, pattern_data, '0, '0);
            end
          end
        end

        WAIT_TICK: begin
          if (stop) begin
            state    <= IDLE;
            busy     <= 1'b0;
            tick_cnt <= '0;
          end else if (tick_cnt == TICK_LAST) begin
            tick_cnt  <= '0;
            to_cnt    <= '0;
            state     <= WRITE;
            fb_we     <= 1'b1;
            fb_w_xpos <= cur_x;
            fb_w_ypos <= cur_y;
            fb_din    <= pixel_data(mode_q, data_q, cur_x, cur_y);
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        WRITE: begin
          if (fb_w_data_valid) begin
            fb_we     <= 1'b0;
            to_cnt    <= '0;
            stop_pend <= stop_pend | stop;
            state     <= ACK_LOW;
          end else if (to_cnt == TO_LAST) begin
            // Abandon the write; a pending stop is moot once the run is aborted.
            err       <= 1'b1;
            fb_we     <= 1'b0;
            busy      <= 1'b0;
            to_cnt    <= '0;
            stop_pend <= 1'b0;
            state     <= IDLE;
          end else begin
            to_cnt    <= to_cnt + 1'b1;
            stop_pend <= stop_pend | stop;
          end
        end

        // Hold off the next write until the acknowledge has been released.
        ACK_LOW: begin
          stop_pend <= stop_pend | stop;
          if (!fb_w_data_valid) begin
            state <= ADVANCE;
          end
        end

        ADVANCE: begin
          if (stop || stop_pend) begin
            stop_pend <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            cur_x <= nx;
            cur_y <= ny;
            if (mode_q == MODE_WALK) begin
              state <= WAIT_TICK;
            end else if (frame_last) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              to_cnt    <= '0;
              state     <= WRITE;
              fb_we     <= 1'b1;
              fb_w_xpos <= nx;
              fb_w_ypos <= ny;
              fb_din    <= pixel_data(mode_q, data_q, nx, ny);
            end
          end
        end

        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          fb_we <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_pattern_writer.sv
// tb/tb_fb_pattern_writer.sv - directed self-checking bench for fb_pattern_writer
module tb_fb_pattern_writer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [7:0] pattern_data;
  logic       fb_we;
  logic [7:0] fb_w_xpos;
  logic [7:0] fb_w_ypos;
  logic [7:0] fb_din;
  logic       fb_w_data_valid;
  logic       busy;
  logic       done;
  logic       err;

  int errors = 0;
  int checks = 0;

  fb_pattern_writer #(
    .FB_WIDTH   (4),
    .FB_HEIGHT  (2),
    .TICK_CYCLES(3),
    .ACK_TIMEOUT(8),
    .XW         (8),
    .YW         (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .stop           (stop),
    .mode           (mode),
    .pattern_data   (pattern_data),
    .fb_we          (fb_we),
    .fb_w_xpos      (fb_w_xpos),
    .fb_w_ypos      (fb_w_ypos),
    .fb_din         (fb_din),
    .fb_w_data_valid(fb_w_data_valid),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Acknowledge model: rises 2 cycles after fb_we, stays high for 1 cycle.
  logic ack_en;
  int   wcnt;
  always @(posedge clk) begin
    if (fb_w_data_valid) begin
      fb_w_data_valid <= 1'b0;
      wcnt            <= 0;
    end else if (ack_en && fb_we) begin
      if (wcnt == 1) begin
        fb_w_data_valid <= 1'b1;
        wcnt            <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  // Monitors, sampled on the falling edge.
  int          cyc = 0;
  logic [23:0] wlog[$];
  int          rises[$];
  int          done_cnt;
  int          we_hi_cnt;
  int          viol;
  logic        we_prev  = 1'b0;
  logic        hs_prev  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fb_we && fb_w_data_valid) wlog.push_back({fb_w_xpos, fb_w_ypos, fb_din});
    if (fb_we && !we_prev) rises.push_back(cyc);
    if (done) done_cnt++;
    if (fb_we) we_hi_cnt++;
    if (fb_we && !we_prev && fb_w_data_valid) viol++;
    if (hs_prev && fb_we) viol++;
    hs_prev = fb_we && fb_w_data_valid;
    we_prev = fb_we;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wlog.delete();
    rises.delete();
    done_cnt  = 0;
    we_hi_cnt = 0;
    viol      = 0;
  endtask

  // Start pulse, then scramble mode/data to show they were latched.
  task automatic start_run(input logic [1:0] m, input logic [7:0] d);
    @(negedge clk);
    mode         = m;
    pattern_data = d;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    mode         = m ^ 2'b01;
    pattern_data = ~d;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_log(input string tag, input int cnt, input int limit);
    int n = 0;
    while (wlog.size() < cnt && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, wlog.size() >= cnt}, 32'd1);
  endtask

  logic [7:0] chk_exp [8];

  initial begin
    chk_exp = '{8'h55, 8'hAA, 8'h55, 8'hAA, 8'hAA, 8'h55, 8'hAA, 8'h55};
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0; pattern_data = 8'h00;
    ack_en = 1'b1; fb_w_data_valid = 1'b0; wcnt = 0;
    clear_mon();

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", {4'd0, fb_we, busy, done, err, fb_w_xpos, fb_w_ypos, fb_din}, 32'd0);
    rst = 1'b0;

    // FILL 3C
    clear_mon();
    start_run(2'd1, 8'h3C);
    check("fill_busy", {31'd0, busy}, 32'd1);
    wait_idle("fill_idle", 200);
    check("fill_count", wlog.size(), 8);
    for (int i = 0; i < 8 && i < wlog.size(); i++)
      check($sformatf("fill_w%0d", i), {8'd0, wlog[i]}, {8'd0, 8'(i % 4), 8'(i / 4), 8'h3C});
    check("fill_done", done_cnt, 1);

    // CHECKER
    clear_mon();
    start_run(2'd3, 8'h11);
    wait_idle("chk_idle", 200);
    check("chk_count", wlog.size(), 8);
    for (int i = 0; i < 8 && i < wlog.size(); i++)
      check($sformatf("chk_w%0d", i), {8'd0, wlog[i]}, {8'd0, 8'(i % 4), 8'(i / 4), chk_exp[i]});
    check("chk_ack_overlap", viol, 0);
    check("chk_done", done_cnt, 1);

    // WALK FF: one write per 8 cycles, wraps without done
    clear_mon();
    start_run(2'd0, 8'hFF);
    wait_log("walk_wait", 9, 300);
    for (int i = 0; i < 9 && i < wlog.size(); i++)
      check($sformatf("walk_w%0d", i), {8'd0, wlog[i]}, {8'd0, 8'(i % 4), 8'((i / 4) % 2), 8'hFF});
    if (rises.size() >= 2) check("walk_period", rises[1] - rises[0], 8);
    else check("walk_rises", rises.size(), 2);
    check("walk_no_done", done_cnt, 0);
    check("walk_busy", {31'd0, busy}, 32'd1);
    stop = 1'b1;
    wait_idle("walk_stop_idle", 40);
    stop = 1'b0;
    check("walk_stop_no_done", done_cnt, 0);

    // Stop during WRITE of (2,0)
    clear_mon();
    start_run(2'd1, 8'h3C);
    begin
      int n = 0;
      while (!(fb_we && fb_w_xpos == 8'd2 && fb_w_ypos == 8'd0) && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("stop_reach_x2", {31'd0, fb_we}, 32'd1);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_idle("stop_idle", 50);
    check("stop_count", wlog.size(), 3);
    if (wlog.size() >= 3) check("stop_last", {8'd0, wlog[2]}, {8'd0, 8'd2, 8'd0, 8'h3C});
    check("stop_no_done", done_cnt, 0);

    // Acknowledge timeout
    clear_mon();
    ack_en = 1'b0;
    start_run(2'd1, 8'h3C);
    wait_idle("to_idle", 50);
    check("to_we_cycles", we_hi_cnt, 8);
    check("to_err", {31'd0, err}, 32'd1);
    check("to_no_done", done_cnt, 0);
    ack_en = 1'b1;
    clear_mon();
    start_run(2'd2, 8'h77);
    check("to_restart_busy", {31'd0, busy}, 32'd1);
    wait_idle("clr_idle", 200);
    check("clr_count", wlog.size(), 8);
    if (wlog.size() >= 8) check("clr_last", {8'd0, wlog[7]}, {8'd0, 8'd3, 8'd1, 8'h00});
    check("clr_done", done_cnt, 1);
    check("err_sticky", {31'd0, err}, 32'd1);

    // Reset while fb_we=1
    clear_mon();
    start_run(2'd1, 8'h3C);
    wait_log("rst_wait", 2, 100);
    begin
      int n = 0;
      while (!fb_we && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("rst_we_seen", {31'd0, fb_we}, 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", {4'd0, fb_we, busy, done, err, fb_w_xpos, fb_w_ypos, fb_din}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    clear_mon();
    start_run(2'd1, 8'h3C);
    wait_log("rst_restart", 1, 50);
    if (wlog.size() >= 1) check("rst_first_write", {8'd0, wlog[0]}, {8'd0, 8'd0, 8'd0, 8'h3C});
    wait_idle("rst_final_idle", 200);
    check("rst_final_done", done_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
